// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the slave response FSM state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } slave_state_e;

endpackage

// File: rtl/ham_check.sv
// Decode side of the write-path encoder: one parity bit per 16-bit half.
module ham_check (
    input  logic [33:0] code_i,
    output logic [31:0] data_o,
    output logic        parity_err_o
);

    assign data_o       = code_i[31:0];
    assign parity_err_o = (code_i[32] != ^code_i[15:0]) | (code_i[33] != ^code_i[31:16]);

endmodule

// File: rtl/ahb_ecc_slave.sv
// Single-word AHB memory slave that rejects write data failing its check bits.
//
// state | meaning
// IDLE  | no data phase, or a zero-wait data phase completing this cycle
// WAIT  | inserting wait states; completes when the counter reaches zero
// ERR1  | first ERROR cycle (hreadyout low); presented in the failing completion cycle
// ERR2  | second ERROR cycle (hreadyout high); next address phase may be taken
module ahb_ecc_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [33:0] hwdata,
    output logic        hreadyout,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata,
    output logic [7:0]  err_cnt
);

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    slave_state_e       state_q, state_d, phase;
    logic [2:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q;
    logic               write_q, size_ok_q, valid_q;
    logic [7:0]         err_cnt_q;
    logic [31:0]        mem_q [DEPTH];

    logic [31:0] wdata;
    logic        parity_err, completing, xfer_err, err_now, wr_en, addr_ph;
    logic        unused_bits;

    assign unused_bits = ^{hburst, haddr[31:ADDR_W+2], haddr[1:0]};

    ham_check u_ham_check (
        .code_i       (hwdata),
        .data_o       (wdata),
        .parity_err_o (parity_err)
    );

    always_comb begin
        completing = 1'b0;
        if (valid_q) begin
            if (state_q == ST_IDLE && WAIT_STATES == 0) completing = 1'b1;
            if (state_q == ST_WAIT && cnt_q == 3'd0)    completing = 1'b1;
        end
    end

    assign xfer_err = !size_ok_q || (write_q && parity_err);
    assign err_now  = completing && xfer_err;
    assign wr_en    = completing && !xfer_err && write_q;
    // A failing completion must already drive hreadyout low, so it is the ERR1 cycle.
    assign phase    = err_now ? ST_ERR1 : state_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (phase)
            ST_IDLE: begin
                if (valid_q && WAIT_STATES > 0) begin
                    hreadyout = 1'b0;
                    state_d   = ST_WAIT;
                    cnt_d     = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hreadyout = 1'b0;
                    cnt_d     = cnt_q - 3'd1;
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                hresp   = HRESP_ERROR;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign addr_ph = hsel && hreadyout && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_ok_q <= 1'b0;
            valid_q   <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (hreadyout) begin
                valid_q <= addr_ph;
                if (addr_ph) begin
                    addr_q    <= haddr[ADDR_W+1:2];
                    write_q   <= hwrite;
                    size_ok_q <= (hsize == HSIZE_WORD);
                end
            end else if (err_now) begin
                valid_q <= 1'b0;
            end
            if (err_now && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    // Contents survive reset; wr_en is forced low while reset holds the FSM.
    always_ff @(posedge hclk) begin
        if (wr_en) mem_q[addr_q] <= wdata;
    end

    assign hrdata  = (valid_q && !write_q && size_ok_q) ? mem_q[addr_q] : 32'd0;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ahb_ecc_slave.sv
// Bench for ahb_ecc_slave: zero-wait and two-wait-state instances against an array model.
module tb_ahb_ecc_slave;
    import ahb_pkg::*;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        hsel_req = 1'b0;
    int          which = 0;
    logic        hsel0, hsel1;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [2:0]  hburst = 3'b000;
    logic [33:0] hwdata = '0;

    logic        ready0, ready1;
    logic [1:0]  resp0, resp1;
    logic [31:0] rdata0, rdata1;
    logic [7:0]  errc0, errc1;
    logic        cur_ready;
    logic [1:0]  cur_resp;
    logic [31:0] cur_rdata;
    logic [7:0]  cur_errc;

    assign hsel0     = hsel_req && (which == 0);
    assign hsel1     = hsel_req && (which == 1);
    assign cur_ready = (which == 1) ? ready1 : ready0;
    assign cur_resp  = (which == 1) ? resp1  : resp0;
    assign cur_rdata = (which == 1) ? rdata1 : rdata0;
    assign cur_errc  = (which == 1) ? errc1  : errc0;

    ahb_ecc_slave #(.ADDR_W(6), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hreadyout(ready0), .hresp(resp0), .hrdata(rdata0), .err_cnt(errc0)
    );

    ahb_ecc_slave #(.ADDR_W(6), .WAIT_STATES(2)) dut1 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hreadyout(ready1), .hresp(resp1), .hrdata(rdata1), .err_cnt(errc1)
    );

    always #5 hclk = ~hclk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [2][64];
    int          ecnt [2];
    int          r_low;
    logic [1:0]  r_lastlow, r_resp;
    logic [31:0] r_rdata;
    logic        done;

    function automatic logic [33:0] enc(logic [31:0] d);
        return {^d[31:16], ^d[15:0], d};
    endfunction

    function automatic int ws_of(int d);
        return (d == 1) ? 2 : 0;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge hclk);
            if (cur_ready === 1'b1) begin
                r_resp  = cur_resp;
                r_rdata = cur_rdata;
                done    = 1'b1;
                break;
            end
            r_low++;
            r_lastlow = cur_resp;
            @(posedge hclk); #1;
        end
        check("data_phase_done", 32'(done), 32'd1);
    endtask

    // Address phase, then a data phase with hsel dropped and hwdata presented.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [1:0] trans, input logic [33:0] wd);
        which = d;
        @(posedge hclk); #1;
        hsel_req = 1'b1; haddr = addr; htrans = trans; hwrite = wr; hsize = size;
        hburst = 3'($urandom_range(0, 7));
        @(posedge hclk); #1;
        hsel_req = 1'b0; htrans = HTRANS_IDLE; hwdata = wd;
        r_low = 0; r_lastlow = HRESP_OKAY;
        wait_ready();
    endtask

    task automatic run_and_check(string tag, int d, logic wr, logic [31:0] addr,
                                 logic [2:0] size, logic [1:0] trans, logic [31:0] data,
                                 logic [33:0] flip);
        logic [5:0]  idx;
        logic        active, bad;
        int          exp_low;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        idx    = addr[7:2];
        active = trans[1];
        bad    = active && (size != 3'b010 || (wr && flip != 34'd0));
        xfer(d, wr, addr, size, trans, enc(data) ^ flip);
        exp_rdata = 32'd0;
        exp_resp  = HRESP_OKAY;
        exp_low   = 0;
        if (bad) begin
            exp_low  = ws_of(d) + 1;
            exp_resp = HRESP_ERROR;
            ecnt[d]  = (ecnt[d] < 255) ? ecnt[d] + 1 : 255;
        end else if (active) begin
            exp_low = ws_of(d);
            if (wr) mem_m[d][idx] = data;
            else    exp_rdata = mem_m[d][idx];
        end
        check($sformatf("%s wait_cycles", tag), 32'(r_low), 32'(exp_low));
        check($sformatf("%s hresp", tag), 32'(r_resp), 32'(exp_resp));
        check($sformatf("%s hrdata", tag), r_rdata, exp_rdata);
        if (bad) check($sformatf("%s first_err_resp", tag), 32'(r_lastlow), 32'(HRESP_ERROR));
        check($sformatf("%s err_cnt", tag), 32'(cur_errc), 32'(ecnt[d]));
    endtask

    // Write immediately followed by a pipelined read of the same word.
    task automatic pipe_wr_rd(int d, logic [31:0] addr, logic [31:0] data);
        which = d;
        @(posedge hclk); #1;
        hsel_req = 1'b1; haddr = addr; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge hclk); #1;
        hwdata = enc(data); hwrite = 1'b0; htrans = HTRANS_SEQ;
        r_low = 0;
        wait_ready();
        check($sformatf("pipe%0d wr hresp", d), 32'(r_resp), 32'(HRESP_OKAY));
        check($sformatf("pipe%0d wr wait_cycles", d), 32'(r_low), 32'(ws_of(d)));
        mem_m[d][addr[7:2]] = data;
        @(posedge hclk); #1;
        hsel_req = 1'b0; htrans = HTRANS_IDLE;
        r_low = 0;
        wait_ready();
        check($sformatf("pipe%0d rd hrdata", d), r_rdata, data);
        check($sformatf("pipe%0d rd wait_cycles", d), 32'(r_low), 32'(ws_of(d)));
    endtask

    initial begin
        logic [31:0] a, dat, old;
        logic [33:0] fl;
        int          k;
        ecnt[0] = 0; ecnt[1] = 0;

        #12;
        check("reset ready0", 32'(ready0), 32'd1);
        check("reset resp0", 32'(resp0), 32'd0);
        check("reset rdata0", rdata0, 32'd0);
        check("reset errc0", 32'(errc0), 32'd0);
        check("reset ready1", 32'(ready1), 32'd1);
        check("reset errc1", 32'(errc1), 32'd0);
        @(negedge hclk); hresetn = 1'b1;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++)
                run_and_check("fill", d, 1'b1, 32'(i) << 2, HSIZE_WORD, HTRANS_NONSEQ, $urandom(), 34'd0);

        run_and_check("wr10", 0, 1'b1, 32'h10, HSIZE_WORD, HTRANS_NONSEQ, 32'hDEADBEEF, 34'd0);
        run_and_check("rd10", 0, 1'b0, 32'h10, HSIZE_WORD, HTRANS_NONSEQ, 32'd0, 34'd0);
        run_and_check("wr20_bad33", 0, 1'b1, 32'h20, HSIZE_WORD, HTRANS_NONSEQ, 32'h12345678, 34'h2_0000_0000);
        run_and_check("rd20_old", 0, 1'b0, 32'h20, HSIZE_WORD, HTRANS_NONSEQ, 32'd0, 34'd0);

        run_and_check("ws2_rd", 1, 1'b0, 32'h10, HSIZE_WORD, HTRANS_NONSEQ, 32'd0, 34'd0);
        pipe_wr_rd(1, 32'h30, 32'hA5A5_0F0F);
        pipe_wr_rd(0, 32'h34, 32'h0123_4567);

        run_and_check("size0_rd_ws0", 0, 1'b0, 32'h10, 3'b000, HTRANS_NONSEQ, 32'd0, 34'd0);
        run_and_check("size0_rd_ws2", 1, 1'b0, 32'h10, 3'b000, HTRANS_NONSEQ, 32'd0, 34'd0);
        run_and_check("idle_wr", 0, 1'b1, 32'h10, HSIZE_WORD, HTRANS_IDLE, 32'hFFFF_0000, 34'd0);
        run_and_check("busy_wr", 0, 1'b1, 32'h10, HSIZE_WORD, HTRANS_BUSY, 32'h0000_FFFF, 34'd0);
        run_and_check("rd10_after_idle", 0, 1'b0, 32'h10, HSIZE_WORD, HTRANS_NONSEQ, 32'd0, 34'd0);

        for (int n = 0; n < 150; n++) begin
            int          d, kind;
            logic        wr;
            logic [2:0]  sz;
            logic [1:0]  tr;
            d    = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            a    = (32'($urandom_range(0, 63)) << 2) | (32'($urandom_range(0, 3)) << 28);
            dat  = $urandom();
            wr   = (kind < 4) || (kind == 7) || (kind == 8 && dat[0]);
            sz   = HSIZE_WORD;
            tr   = dat[1] ? HTRANS_SEQ : HTRANS_NONSEQ;
            fl   = 34'd0;
            if (kind == 7) fl = 34'd1 << $urandom_range(0, 33);
            if (kind == 8) begin
                k  = $urandom_range(0, 3);
                sz = (k == 0) ? 3'b000 : (k == 1) ? 3'b001 : (k == 2) ? 3'b011 : 3'b100;
            end
            if (kind == 9) tr = dat[2] ? HTRANS_BUSY : HTRANS_IDLE;
            run_and_check($sformatf("rand%0d", n), d, wr, a, sz, tr, dat, fl);
        end

        for (int n = 0; n < 300; n++)
            run_and_check("sat", 0, 1'b1, 32'h44, HSIZE_WORD, HTRANS_NONSEQ, $urandom(), 34'd1 << (n % 34));
        check("sat err_cnt", 32'(errc0), 32'd255);
        run_and_check("sat_rd44", 0, 1'b0, 32'h44, HSIZE_WORD, HTRANS_NONSEQ, 32'd0, 34'd0);

        which = 1;
        old = mem_m[1][6'h11];
        @(posedge hclk); #1;
        hsel_req = 1'b1; haddr = 32'h44; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge hclk); #1;
        hsel_req = 1'b0; htrans = HTRANS_IDLE; hwdata = enc(~old);
        @(posedge hclk); #1;
        check("pre_reset waiting", 32'(ready1), 32'd0);
        hresetn = 1'b0;
        #1;
        check("mid_reset ready1", 32'(ready1), 32'd1);
        check("mid_reset resp1", 32'(resp1), 32'd0);
        check("mid_reset rdata1", rdata1, 32'd0);
        check("mid_reset errc1", 32'(errc1), 32'd0);
        check("mid_reset errc0", 32'(errc0), 32'd0);
        ecnt[0] = 0; ecnt[1] = 0;
        @(negedge hclk); hresetn = 1'b1;
        run_and_check("post_reset_rd44", 1, 1'b0, 32'h44, HSIZE_WORD, HTRANS_NONSEQ, 32'd0, 34'd0);
        run_and_check("post_reset_rd10", 0, 1'b0, 32'h10, HSIZE_WORD, HTRANS_NONSEQ, 32'd0, 34'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
